// File: rtl/lcd_pkg.sv
// Shared LCD controller definitions: FSM states, instruction opcodes and DDRAM address helpers.
// Used by the bus responder and by the write driver.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  localparam int unsigned DDRAM_DEPTH = 80;
  localparam logic [7:0]  FILL_CHAR   = 8'h20;

  // An instruction belongs to class op when its highest set bit is op's bit.
  function automatic logic cmd_is(input logic [7:0] d, input logic [7:0] op);
    return (d & ~(op - 8'd1)) == op;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  // Line 2 (0x40-0x67) occupies storage slots 40-79.
  function automatic logic [6:0] addr_idx(input logic [6:0] a);
    return a[6] ? ({1'b0, a[5:0]} + 7'd40) : a;
  endfunction

  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    logic [6:0] n;
    if (inc) begin
      if (a == 7'h27)      n = 7'h40;
      else if (a == 7'h67) n = 7'h00;
      else                 n = a + 7'd1;
    end else begin
      if (a == 7'h40)      n = 7'h27;
      else if (a == 7'h00) n = 7'h67;
      else                 n = a - 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// Parallel LCD bus between an initiator (master) and the responder (slave).
interface lcd_bus_responder_if;
  logic [7:0] dat;
  logic       rs;
  logic       rw;
  logic       en;
  logic [7:0] dat_out;
  logic       dat_oe;

  modport master (output dat, rs, rw, en, input dat_out, dat_oe);
  modport slave  (input dat, rs, rw, en, output dat_out, dat_oe);
endinterface

// File: rtl/lcd_bus_sync.sv
// Two-stage synchroniser for the asynchronous LCD bus plus en falling-edge strobe.
// Strobe fires the cycle after the synchronised 1->0 transition, with rs/rw/dat captured at that edge.
module lcd_bus_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic [7:0] i_dat,
  output logic       o_en,
  output logic       o_rs,
  output logic       o_rw,
  output logic       o_stb,
  output logic       o_stb_rs,
  output logic       o_stb_rw,
  output logic [7:0] o_stb_dat
);

  logic [10:0] r_s1;
  logic [10:0] r_s2;
  logic        r_en_prev;
  logic        r_stb;
  logic        r_stb_rs;
  logic        r_stb_rw;
  logic [7:0]  r_stb_dat;
  logic        w_fall;

  assign w_fall = r_en_prev & ~r_s2[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_en_prev <= 1'b0;
      r_stb     <= 1'b0;
      r_stb_rs  <= 1'b0;
      r_stb_rw  <= 1'b0;
      r_stb_dat <= 8'h00;
    end else begin
      r_s1      <= {i_en, i_rs, i_rw, i_dat};
      r_s2      <= r_s1;
      r_en_prev <= r_s2[10];
      r_stb     <= w_fall;
      if (w_fall) begin
        r_stb_rs  <= r_s2[9];
        r_stb_rw  <= r_s2[8];
        r_stb_dat <= r_s2[7:0];
      end
    end
  end

  assign o_en      = r_s2[10];
  assign o_rs      = r_s2[9];
  assign o_rw      = r_s2[8];
  assign o_stb     = r_stb;
  assign o_stb_rs  = r_stb_rs;
  assign o_stb_rw  = r_stb_rw;
  assign o_stb_dat = r_stb_dat;

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style LCD bus responder: decodes instructions, holds 80-byte DDRAM and models the busy flag.
// Writes while busy are dropped with a cmd_err pulse; reads are answered in any state.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 2000,
  parameter int unsigned CLR_CYCLES  = 82000
) (
  input  logic                clk,
  input  logic                rst_n,
  lcd_bus_responder_if.slave  bus,
  output logic                disp_on,
  output logic                cursor_on,
  output logic                blink_on,
  output logic                entry_inc,
  output logic                entry_shift,
  output logic                line2,
  output logic [6:0]          ac,
  output logic                busy,
  output logic                cmd_err,
  input  logic [6:0]          scan_addr,
  output logic [7:0]          scan_data
);

  // FILL itself spends one cycle per location, so EXEC covers the remainder.
  localparam logic [31:0] FILL_REST = (CLR_CYCLES > DDRAM_DEPTH) ?
                                      32'(CLR_CYCLES - DDRAM_DEPTH) : 32'd1;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [6:0]  r_fill_idx;
  logic [6:0]  r_ac;
  logic        r_disp_on, r_cursor_on, r_blink_on;
  logic        r_entry_inc, r_entry_shift, r_line2;
  logic        r_busy, r_cmd_err;
  logic [7:0]  r_dat_out;
  logic        r_dat_oe;
  logic [7:0]  r_scan;
  logic [7:0]  r_mem [DDRAM_DEPTH];

  logic        w_en_s, w_rs_s, w_rw_s;
  logic        w_stb, w_stb_rs, w_stb_rw;
  logic [7:0]  w_stb_dat;
  logic        w_wr_stb, w_rd_data_stb;
  logic        w_go_exec, w_go_fill, w_reject;
  logic [31:0] w_exec_cnt;
  logic        w_mem_we;
  logic [6:0]  w_mem_idx;
  logic [7:0]  w_mem_wdat;

  lcd_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (bus.en),
    .i_rs      (bus.rs),
    .i_rw      (bus.rw),
    .i_dat     (bus.dat),
    .o_en      (w_en_s),
    .o_rs      (w_rs_s),
    .o_rw      (w_rw_s),
    .o_stb     (w_stb),
    .o_stb_rs  (w_stb_rs),
    .o_stb_rw  (w_stb_rw),
    .o_stb_dat (w_stb_dat)
  );

  assign w_wr_stb      = w_stb & ~w_stb_rw;
  assign w_rd_data_stb = w_stb & w_stb_rw & w_stb_rs;

  always_comb begin
    w_go_exec  = 1'b0;
    w_go_fill  = 1'b0;
    w_reject   = 1'b0;
    w_exec_cnt = 32'(BUSY_CYCLES);
    if (w_wr_stb) begin
      if (r_state != ST_IDLE) begin
        w_reject = 1'b1;
      end else if (w_stb_rs) begin
        w_go_exec = 1'b1;
      end else if (cmd_is(w_stb_dat, CMD_DDRAM)) begin
        w_go_exec = addr_valid(w_stb_dat[6:0]);
        w_reject  = ~addr_valid(w_stb_dat[6:0]);
      end else if (cmd_is(w_stb_dat, CMD_CGRAM)) begin
        w_reject = 1'b1;
      end else if (cmd_is(w_stb_dat, CMD_FUNC) || cmd_is(w_stb_dat, CMD_SHIFT) ||
                   cmd_is(w_stb_dat, CMD_DISP) || cmd_is(w_stb_dat, CMD_ENTRY)) begin
        w_go_exec = 1'b1;
      end else if (cmd_is(w_stb_dat, CMD_HOME)) begin
        w_go_exec  = 1'b1;
        w_exec_cnt = 32'(CLR_CYCLES);
      end else if (cmd_is(w_stb_dat, CMD_CLEAR)) begin
        w_go_fill = 1'b1;
      end else begin
        w_reject = 1'b1;
      end
    end
  end

  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_idx  = 7'd0;
    w_mem_wdat = 8'h00;
    if (r_state == ST_FILL) begin
      w_mem_we   = 1'b1;
      w_mem_idx  = r_fill_idx;
      w_mem_wdat = FILL_CHAR;
    end else if (w_go_exec && w_stb_rs) begin
      w_mem_we   = 1'b1;
      w_mem_idx  = addr_idx(r_ac);
      w_mem_wdat = w_stb_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FILL;
      r_cnt         <= FILL_REST;
      r_fill_idx    <= 7'd0;
      r_ac          <= 7'h00;
      r_disp_on     <= 1'b0;
      r_cursor_on   <= 1'b0;
      r_blink_on    <= 1'b0;
      r_entry_inc   <= 1'b1;
      r_entry_shift <= 1'b0;
      r_line2       <= 1'b0;
      r_busy        <= 1'b1;
      r_cmd_err     <= 1'b0;
      r_dat_out     <= 8'h00;
      r_dat_oe      <= 1'b0;
      r_scan        <= 8'h00;
    end else begin
      r_cmd_err <= w_reject;
      r_dat_oe  <= w_en_s & w_rw_s;
      r_dat_out <= (w_en_s & w_rw_s) ? (w_rs_s ? r_mem[addr_idx(r_ac)] : {r_busy, r_ac}) : 8'h00;
      r_scan    <= addr_valid(scan_addr) ? r_mem[addr_idx(scan_addr)] : 8'h00;
      if (w_rd_data_stb) r_ac <= addr_step(r_ac, r_entry_inc);
      case (r_state)
        ST_FILL: begin
          r_fill_idx <= r_fill_idx + 7'd1;
          if (r_fill_idx == 7'(DDRAM_DEPTH - 1)) begin
            r_state <= ST_EXEC;
            r_ac    <= 7'h00;
          end
        end
        ST_EXEC: begin
          if (r_cnt <= 32'd1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: begin
          if (w_go_fill) begin
            r_state     <= ST_FILL;
            r_fill_idx  <= 7'd0;
            r_cnt       <= FILL_REST;
            r_ac        <= 7'h00;
            r_entry_inc <= 1'b1;
            r_busy      <= 1'b1;
          end else if (w_go_exec) begin
            r_state <= ST_EXEC;
            r_cnt   <= w_exec_cnt;
            r_busy  <= 1'b1;
            if (w_stb_rs) begin
              r_ac <= addr_step(r_ac, r_entry_inc);
            end else if (cmd_is(w_stb_dat, CMD_DDRAM)) begin
              r_ac <= w_stb_dat[6:0];
            end else if (cmd_is(w_stb_dat, CMD_FUNC)) begin
              r_line2 <= w_stb_dat[3];
            end else if (cmd_is(w_stb_dat, CMD_SHIFT)) begin
              if (!w_stb_dat[3]) r_ac <= addr_step(r_ac, w_stb_dat[2]);
            end else if (cmd_is(w_stb_dat, CMD_DISP)) begin
              r_disp_on   <= w_stb_dat[2];
              r_cursor_on <= w_stb_dat[1];
              r_blink_on  <= w_stb_dat[0];
            end else if (cmd_is(w_stb_dat, CMD_ENTRY)) begin
              r_entry_inc   <= w_stb_dat[1];
              r_entry_shift <= w_stb_dat[0];
            end else begin
              r_ac <= 7'h00;
            end
          end
        end
      endcase
    end
  end

  assign bus.dat_out = r_dat_out;
  assign bus.dat_oe  = r_dat_oe;
  assign disp_on     = r_disp_on;
  assign cursor_on   = r_cursor_on;
  assign blink_on    = r_blink_on;
  assign entry_inc   = r_entry_inc;
  assign entry_shift = r_entry_shift;
  assign line2       = r_line2;
  assign ac          = r_ac;
  assign busy        = r_busy;
  assign cmd_err     = r_cmd_err;
  assign scan_data   = r_scan;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Scenario bench for lcd_bus_responder with shortened busy times; expected bytes go through a scoreboard queue.
module tb_lcd_bus_responder;

  localparam int unsigned BUSY = 200;
  localparam int unsigned CLR  = 600;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       disp_on, cursor_on, blink_on, entry_inc, entry_shift, line2;
  logic [6:0] ac;
  logic       busy, cmd_err;
  logic [6:0] scan_addr = 7'h00;
  logic [7:0] scan_data;

  int errors = 0;
  int checks = 0;
  int n_err_pulses = 0;
  logic [7:0] exp_q[$];

  lcd_bus_responder_if bus ();

  lcd_bus_responder #(.BUSY_CYCLES(BUSY), .CLR_CYCLES(CLR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .disp_on     (disp_on),
    .cursor_on   (cursor_on),
    .blink_on    (blink_on),
    .entry_inc   (entry_inc),
    .entry_shift (entry_shift),
    .line2       (line2),
    .ac          (ac),
    .busy        (busy),
    .cmd_err     (cmd_err),
    .scan_addr   (scan_addr),
    .scan_data   (scan_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && cmd_err === 1'b1) n_err_pulses++;

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic bus_write(input logic rs_i, input logic [7:0] d);
    @(negedge clk);
    bus.rs = rs_i; bus.rw = 1'b0; bus.dat = d;
    repeat (2) @(negedge clk);
    bus.en = 1'b1;
    repeat (4) @(negedge clk);
    bus.en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus_read(input logic rs_i, output logic [7:0] d, output logic oe);
    @(negedge clk);
    bus.rs = rs_i; bus.rw = 1'b1;
    repeat (2) @(negedge clk);
    bus.en = 1'b1;
    repeat (5) @(negedge clk);
    d  = bus.dat_out;
    oe = bus.dat_oe;
    bus.en = 1'b0;
    repeat (6) @(negedge clk);
    bus.rw = 1'b0;
  endtask

  task automatic scan(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk);
    scan_addr = a;
    @(negedge clk);
    d = scan_data;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 4 * CLR) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic cmd(input logic [7:0] c);
    bus_write(1'b0, c);
    wait_idle();
  endtask

  task automatic test_reset();
    int n = 0;
    bus.en = 1'b0; bus.rs = 1'b0; bus.rw = 1'b0; bus.dat = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, entry_inc, ac} !== {1'b1, 1'b1, 7'h00}) begin
      errors++;
      $display("FAIL reset_busy_inc_ac: got %b required %b", {busy, entry_inc, ac}, {2'b11, 7'h00});
    end
    checks++;
    if ({disp_on, cursor_on, blink_on, entry_shift, line2, cmd_err, bus.dat_oe, bus.dat_out} !== 15'h0) begin
      errors++;
      $display("FAIL reset_zero_outputs: got %h required 0",
               {disp_on, cursor_on, blink_on, entry_shift, line2, cmd_err, bus.dat_oe, bus.dat_out});
    end
    rst_n = 1'b1;
    while (busy !== 1'b0 && n < 4 * CLR) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < int'(CLR) - 3 || n > int'(CLR) + 3) begin
      errors++;
      $display("FAIL reset_busy_time: busy for %0d cycles, required about %0d", n, CLR);
    end
  endtask

  task automatic test_status_after_clear();
    logic [7:0] d;
    logic oe;
    bus_write(1'b0, 8'h01);
    bus_read(1'b0, d, oe);
    checks++;
    if (d[7] !== 1'b1 || oe !== 1'b1) begin
      errors++;
      $display("FAIL status_busy: dat_out=%h oe=%b, required bit7=1 oe=1", d, oe);
    end
    wait_idle();
    exp_q.push_back(8'h00);
    bus_read(1'b0, d, oe);
    checks++;
    if (d !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL status_idle: dat_out=%h required 00", d);
    end
    checks++;
    if (bus.dat_oe !== 1'b0) begin
      errors++;
      $display("FAIL oe_release: dat_oe=%b required 0", bus.dat_oe);
    end
  endtask

  task automatic test_hello();
    logic [7:0] msg [5];
    logic [7:0] d;
    msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    cmd(8'h38); cmd(8'h0C); cmd(8'h06); cmd(8'h01); cmd(8'hC0);
    foreach (msg[i]) begin
      bus_write(1'b1, msg[i]);
      exp_q.push_back(msg[i]);
      wait_idle();
    end
    exp_q.push_back(8'h20);
    checks++;
    if ({line2, disp_on, cursor_on, blink_on, entry_inc, entry_shift} !== 6'b110010) begin
      errors++;
      $display("FAIL hello_flags: got %b required 110010",
               {line2, disp_on, cursor_on, blink_on, entry_inc, entry_shift});
    end
    checks++;
    if (ac !== 7'h45) begin
      errors++;
      $display("FAIL hello_ac: ac=%h required 45", ac);
    end
    for (int a = 'h40; a <= 'h45; a++) begin
      scan(7'(a), d);
      checks++;
      if (d !== exp_q[0]) begin
        errors++;
        $display("FAIL hello_scan[%h]: got %h required %h", a, d, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_data_read();
    logic [7:0] d;
    logic oe;
    cmd(8'hC0);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h45);
    for (int i = 0; i < 2; i++) begin
      bus_read(1'b1, d, oe);
      checks++;
      if (d !== exp_q[0] || ac !== 7'(8'h41 + i)) begin
        errors++;
        $display("FAIL data_read%0d: data=%h ac=%h required data=%h ac=%h", i, d, ac, exp_q[0], 8'h41 + i);
      end
      void'(exp_q.pop_front());
    end
    exp_q.push_back(8'h42);
    bus_read(1'b0, d, oe);
    checks++;
    if (d !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL status_ac: dat_out=%h required 42", d);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    cmd(8'hA7);
    bus_write(1'b1, 8'h41); wait_idle();
    checks++;
    if (ac !== 7'h40) begin errors++; $display("FAIL wrap_inc: ac=%h required 40", ac); end
    scan(7'h27, d);
    checks++;
    if (d !== 8'h41) begin errors++; $display("FAIL wrap_inc_data: got %h required 41", d); end
    cmd(8'h04); cmd(8'h80);
    bus_write(1'b1, 8'h42); wait_idle();
    checks++;
    if (ac !== 7'h67) begin errors++; $display("FAIL wrap_dec: ac=%h required 67", ac); end
    scan(7'h00, d);
    checks++;
    if (d !== 8'h42) begin errors++; $display("FAIL wrap_dec_data: got %h required 42", d); end
    cmd(8'hC0); cmd(8'h10);
    checks++;
    if (ac !== 7'h27) begin errors++; $display("FAIL shift_left: ac=%h required 27", ac); end
    cmd(8'h14);
    checks++;
    if (ac !== 7'h40) begin errors++; $display("FAIL shift_right: ac=%h required 40", ac); end
    cmd(8'h18);
    checks++;
    if (ac !== 7'h40) begin errors++; $display("FAIL disp_shift_noop: ac=%h required 40", ac); end
    cmd(8'h06);
  endtask

  task automatic test_busy_ignore();
    logic [7:0] d;
    int p0;
    cmd(8'h90);
    p0 = n_err_pulses;
    bus_write(1'b1, 8'h58);
    repeat (88) @(negedge clk);
    bus_write(1'b1, 8'h59);
    checks++;
    if (n_err_pulses !== p0 + 1) begin
      errors++;
      $display("FAIL busy_write_err: pulses=%0d required %0d", n_err_pulses - p0, 1);
    end
    wait_idle();
    checks++;
    if (ac !== 7'h11) begin errors++; $display("FAIL busy_write_ac: ac=%h required 11", ac); end
    exp_q.push_back(8'h58);
    exp_q.push_back(8'h20);
    for (int a = 'h10; a <= 'h11; a++) begin
      scan(7'(a), d);
      checks++;
      if (d !== exp_q[0]) begin
        errors++;
        $display("FAIL busy_write_mem[%h]: got %h required %h", a, d, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_bad_cmds();
    int p0;
    cmd(8'h85);
    p0 = n_err_pulses;
    bus_write(1'b0, 8'hA8);
    checks++;
    if (n_err_pulses !== p0 + 1 || ac !== 7'h05 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr: pulses=%0d ac=%h busy=%b required 1 05 0", n_err_pulses - p0, ac, busy);
    end
    bus_write(1'b0, 8'h48);
    checks++;
    if (n_err_pulses !== p0 + 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cgram: pulses=%0d busy=%b required 2 0", n_err_pulses - p0, busy);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] d;
    int bad = 0;
    cmd(8'hC5);
    bus_write(1'b1, 8'h5A); wait_idle();
    bus_write(1'b0, 8'h01);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({disp_on, line2, busy, entry_inc, ac} !== {4'b0011, 7'h00}) begin
      errors++;
      $display("FAIL midfill_reset: got %b required %b", {disp_on, line2, busy, entry_inc, ac}, {4'b0011, 7'h00});
    end
    rst_n = 1'b1;
    wait_idle();
    for (int a = 0; a < 128; a++) begin
      if (a <= 'h27 || (a >= 'h40 && a <= 'h67)) begin
        exp_q.push_back(8'h20);
        scan(7'(a), d);
        checks++;
        if (d !== exp_q.pop_front()) begin
          errors++;
          bad++;
          if (bad <= 4) $display("FAIL midfill_scan[%h]: got %h required 20", a, d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_status_after_clear();
    test_hello();
    test_data_read();
    test_wrap();
    test_busy_ignore();
    test_bad_cmds();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 2000, meaning busy time for ordinary commands and data writes (40 us at 50 MHz).
REQ-002 SHALL have parameter CLR_CYCLES, default 82000, meaning busy time for clear display and return home (1.64 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit: 50 MHz system clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port dat, input, 8 bits: LCD data bus from the initiator.
REQ-006 SHALL have port rs, input, 1 bit: 1 = data, 0 = command.
REQ-007 SHALL have port rw, input, 1 bit: 1 = read, 0 = write.
REQ-008 SHALL have port en, input, 1 bit: LCD enable; a transfer strobes on the en falling edge.
REQ-009 SHALL have port dat_out, output, 8 bits: read-back data.
REQ-010 SHALL have port dat_oe, output, 1 bit: drive enable for dat_out.
REQ-011 SHALL have port disp_on, cursor_on, blink_on, output, 1 bit each: display-control flags.
REQ-012 SHALL have port entry_inc, entry_shift, output, 1 bit each: entry-mode flags.
REQ-013 SHALL have port line2, output, 1 bit: function-set N bit.
REQ-014 SHALL have port ac, output, 7 bits: address counter.
REQ-015 SHALL have port busy, output, 1 bit: busy flag.
REQ-016 SHALL have port cmd_err, output, 1 bit: one-cycle pulse on an ignored or unsupported access.
REQ-017 SHALL have port scan_addr, input, 7 bits: DDRAM scan address.
REQ-018 SHALL have port scan_data, output, 8 bits: DDRAM contents at scan_addr, registered, 1-cycle latency.

Function
REQ-019 SHALL synchronise en, rs, rw and dat through two flip-flop stages and detect the en falling edge on the synchronised copy; a strobe is the cycle after the 1->0 transition.
REQ-020 SHALL hold 80 bytes of DDRAM at valid addresses 0x00-0x27 and 0x40-0x67.
REQ-021 Valid AC increment order SHALL be 0x27->0x40 and 0x67->0x00; decrement SHALL be the exact reverse.
REQ-022 A write strobe while busy=1 SHALL be ignored and pulse cmd_err; state and DDRAM SHALL be unchanged.
REQ-023 Data write (rs=1, rw=0) SHALL store dat at DDRAM[ac], step ac per entry_inc, and set busy for BUSY_CYCLES.
REQ-024 Command 0x01 SHALL enter state FILL: write 0x20 to all 80 locations at one per cycle, set ac=0x00 and entry_inc=1, and keep busy for CLR_CYCLES total.
REQ-025 Command 0x02/0x03 SHALL set ac=0x00 and busy for CLR_CYCLES.
REQ-026 Command 0x04-0x07 SHALL set entry_inc=bit1 and entry_shift=bit0.
REQ-027 Command 0x08-0x0F SHALL set disp_on=bit2, cursor_on=bit1 and blink_on=bit0.
REQ-028 Command 0x10-0x1F with bit3=0 SHALL step ac right when bit2=1 and left otherwise; with bit3=1 (display shift) it SHALL be a no-op.
REQ-029 Command 0x20-0x3F SHALL set line2=bit3.
REQ-030 Command 0x40-0x7F (CGRAM) SHALL pulse cmd_err and otherwise be a no-op.
REQ-031 Command 0x80|a SHALL set ac=a when a is valid; when a is invalid it SHALL pulse cmd_err and leave ac unchanged.
REQ-032 Every accepted command except 0x01-0x03 SHALL set busy for BUSY_CYCLES.
REQ-033 On a read with rs=0, rw=1, dat_out SHALL be {busy, ac}.
REQ-034 On a read with rs=1, rw=1, dat_out SHALL be DDRAM[ac]; ac SHALL step on that read's en falling edge.
REQ-035 dat_oe SHALL be 1 while synchronised en=1 and rw=1, and 0 otherwise.
REQ-036 The state machine SHALL be IDLE -> EXEC (busy countdown) -> IDLE, or IDLE -> FILL -> EXEC -> IDLE; busy=1 in every state except IDLE.
REQ-037 Read strobes SHALL be honoured in any state.

Reset
REQ-038 On rst_n=0 all outputs SHALL go to 0 except ac=0x00, entry_inc=1 and busy=1.
REQ-039 After rst_n=0 the block SHALL enter FILL, clearing DDRAM to 0x20 and then counting CLR_CYCLES before IDLE.
REQ-040 Reset asserted mid-FILL or mid-EXEC SHALL restart this sequence.

Structure
REQ-041 The state encoding, command opcode constants and DDRAM address-step function SHALL live in package lcd_pkg, shared with the write driver.
REQ-042 The edge detector and synchronisers SHALL be one sub-module, lcd_bus_sync.

Verification
REQ-043 Scenario: reset, wait out CLR_CYCLES, send 0x38 0x0C 0x06 0x01 0xC0, then "HELLO" -> scan 0x40-0x44 = "HELLO", ac=0x45, line2=1, disp_on=1.
REQ-044 Scenario: write with ac=0x27 and entry_inc=1 -> ac=0x40; write with ac=0x00 and entry_inc=0 -> ac=0x67.
REQ-045 Scenario: data write, then another write 100 cycles later with BUSY_CYCLES=2000 -> cmd_err pulse and DDRAM unchanged.
REQ-046 Scenario: status read immediately after command 0x01 -> dat_out[7]=1; status read after CLR_CYCLES -> dat_out=0x00.
REQ-047 Scenario: command 0xA8 (address 0x28) -> cmd_err pulse, ac unchanged; command 0x48 -> cmd_err pulse, busy stays 0.
REQ-048 Scenario: rst_n pulsed during FILL -> all 80 locations read 0x20 after completion.
